// File: rtl/pkt_src_pkg.sv
// Shared types and constants for the pkt_src packet source.
package pkt_src_pkg;

  localparam int unsigned WORD_W      = 64;
  localparam int unsigned HDR_CNT_MSB = 63;
  localparam int unsigned HDR_CNT_LSB = 56;
  localparam int unsigned HDR_IDX_W   = 3;

  // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59
  localparam logic [WORD_W-1:0] LFSR_TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [WORD_W-1:0] LFSR_SEED_XOR = 64'h0000_0000_0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sof;
    logic              eof;
  } beat_t;

  // Index of the last header word: header count clamped to 1..num_hdr, minus one
  function automatic logic [HDR_IDX_W-1:0] hdr_last_idx(input logic [7:0] top,
                                                        input int unsigned num_hdr);
    logic [7:0] h;
    if (top == 8'd0)                h = 8'd1;
    else if (32'(top) > num_hdr)    h = 8'(num_hdr);
    else                            h = top;
    return HDR_IDX_W'(h - 8'd1);
  endfunction

  function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] s);
    return {s[WORD_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pkt_src_payload.sv
// Payload word generator: incrementing counter, or an LFSR when PKT_SRC_LFSR_EN is defined.
module pkt_src_payload
  import pkt_src_pkg::*;
#(
  parameter int unsigned Width = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [Width-1:0] seed,
  input  logic             adv,
  output logic [Width-1:0] value,
  output logic [Width-1:0] value_nxt_c
);

`ifdef PKT_SRC_LFSR_EN
  assign value_nxt_c = lfsr_step(value);

  always_ff @(posedge CLK) begin
    if (!RST_N)    value <= '0;
    else if (load) value <= seed ^ LFSR_SEED_XOR;
    else if (adv)  value <= value_nxt_c;
  end
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign value_nxt_c = value + Width'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N)    value <= '0;
    else if (load) value <= '0;
    else if (adv)  value <= value_nxt_c;
  end
`endif

endmodule

// File: rtl/pkt_src.sv
// Packet source: streams a latched route header then LEN payload words under backpressure.
// Payload source selected by PKT_SRC_LFSR_EN (counter when undefined).
module pkt_src
  import pkt_src_pkg::*;
#(
  parameter int unsigned NumHdr = 8,
  parameter int unsigned Width  = 64
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          GO,
  input  logic [NumHdr-1:0][WORD_W-1:0] DEST,
  input  logic [WORD_W-1:0]             LEN,
  output logic [Width-1:0]              Q,
  output logic                          Q_VALID,
  input  logic                          Q_BP,
  output logic                          Q_SOF,
  output logic                          Q_EOF,
  output logic                          BUSY,
  output logic                          DONE
);

  state_e                          state_q, state_nxt_c;
  logic [NumHdr-1:0][WORD_W-1:0]   dest_q;
  logic [WORD_W-1:0]               len_q;
  logic [HDR_IDX_W-1:0]            hdr_idx_q, hdr_last_q, hdr_last_in_c;
  logic [WORD_W-1:0]               pay_idx_q;
  beat_t                           beat_q, beat_nxt_c;
  logic                            valid_q, valid_nxt_c;
  logic                            done_q, done_nxt_c;
  logic                            busy_q;
  logic                            xfer_c, hdr_end_c, pay_end_c;
  logic                            pay_load_c, pay_adv_c;
  logic [Width-1:0]                pay_value, pay_nxt_c;

  assign xfer_c        = valid_q & ~Q_BP;
  assign hdr_last_in_c = hdr_last_idx(DEST[0][HDR_CNT_MSB:HDR_CNT_LSB], NumHdr);
  assign hdr_end_c     = (state_q == ST_HDR) && xfer_c && (hdr_idx_q == hdr_last_q);
  assign pay_end_c     = (state_q == ST_PAY) && xfer_c && (pay_idx_q == len_q - 64'd1);

  pkt_src_payload #(.Width(Width)) u_payload (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .load        (pay_load_c),
    .seed        (DEST[0]),
    .adv         (pay_adv_c),
    .value       (pay_value),
    .value_nxt_c (pay_nxt_c)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt_c;
  end

  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      ST_IDLE: if (GO)        state_nxt_c = ST_HDR;
      ST_HDR:  if (hdr_end_c) state_nxt_c = (len_q == 64'd0) ? ST_IDLE : ST_PAY;
      ST_PAY:  if (pay_end_c) state_nxt_c = ST_IDLE;
      default:                state_nxt_c = ST_IDLE;
    endcase
  end

  // Next output beat; everything holds while the current word is stalled
  always_comb begin
    beat_nxt_c  = beat_q;
    valid_nxt_c = valid_q;
    done_nxt_c  = 1'b0;
    pay_load_c  = 1'b0;
    pay_adv_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (GO) begin
          beat_nxt_c.data = DEST[0];
          beat_nxt_c.sof  = 1'b1;
          beat_nxt_c.eof  = (hdr_last_in_c == '0) && (LEN == 64'd0);
          valid_nxt_c     = 1'b1;
          pay_load_c      = 1'b1;
        end
      end
      ST_HDR: begin
        if (xfer_c) begin
          if (hdr_idx_q == hdr_last_q) begin
            if (len_q == 64'd0) begin
              beat_nxt_c  = '0;
              valid_nxt_c = 1'b0;
              done_nxt_c  = 1'b1;
            end else begin
              beat_nxt_c.data = pay_value;
              beat_nxt_c.sof  = 1'b0;
              beat_nxt_c.eof  = (len_q == 64'd1);
            end
          end else begin
            beat_nxt_c.data = dest_q[HDR_IDX_W'(hdr_idx_q + 3'd1)];
            beat_nxt_c.sof  = 1'b0;
            beat_nxt_c.eof  = (HDR_IDX_W'(hdr_idx_q + 3'd1) == hdr_last_q) && (len_q == 64'd0);
          end
        end
      end
      ST_PAY: begin
        if (xfer_c) begin
          pay_adv_c = 1'b1;
          if (pay_idx_q == len_q - 64'd1) begin
            beat_nxt_c  = '0;
            valid_nxt_c = 1'b0;
            done_nxt_c  = 1'b1;
          end else begin
            beat_nxt_c.data = pay_nxt_c;
            beat_nxt_c.sof  = 1'b0;
            beat_nxt_c.eof  = ((pay_idx_q + 64'd1) == (len_q - 64'd1));
          end
        end
      end
      default: begin
        beat_nxt_c  = '0;
        valid_nxt_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      beat_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dest_q     <= '0;
      len_q      <= '0;
      hdr_last_q <= '0;
      hdr_idx_q  <= '0;
      pay_idx_q  <= '0;
    end else begin
      beat_q  <= beat_nxt_c;
      valid_q <= valid_nxt_c;
      done_q  <= done_nxt_c;
      busy_q  <= (state_nxt_c != ST_IDLE);
      if ((state_q == ST_IDLE) && GO) begin
        dest_q     <= DEST;
        len_q      <= LEN;
        hdr_last_q <= hdr_last_in_c;
        hdr_idx_q  <= '0;
        pay_idx_q  <= '0;
      end
      if ((state_q == ST_HDR) && xfer_c && !hdr_end_c) hdr_idx_q <= HDR_IDX_W'(hdr_idx_q + 3'd1);
      if ((state_q == ST_PAY) && xfer_c)               pay_idx_q <= pay_idx_q + 64'd1;
    end
  end

  assign Q       = beat_q.data;
  assign Q_SOF   = beat_q.sof;
  assign Q_EOF   = beat_q.eof;
  assign Q_VALID = valid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: doc/pkt_src.md
# pkt_src

Per-port packet source feeding one input port of the 4-port 64-bit router (`D`/`D_VALID`/`D_BP`). On a `GO` pulse it latches a route header (up to eight 64-bit words) and a payload length. It then streams the header words followed by generated payload words under downstream backpressure. One instance per router port forms the traffic front end for the processing-element test fabric.

## Interface
Parameters:
- `NumHdr`, 8: depth of the `DEST` header array (1..8).
- `Width`, 64: data word width; fixed at 64 for router compatibility.

Ports:
- `CLK`, input, 1: sole clock; all logic on its rising edge.
- `RST_N`, input, 1: reset, synchronous, active-low.
- `GO`, input, 1: start request, sampled only in IDLE.
- `DEST`, input, [NumHdr-1:0][63:0]: route header words, latched on accepted `GO`.
- `LEN`, input, 64: payload word count, latched on accepted `GO`.
- `Q`, output, 64: data word to router `D`.
- `Q_VALID`, output, 1: `Q` holds a valid word.
- `Q_BP`, input, 1: downstream backpressure from router `D_BP`.
- `Q_SOF`, output, 1: high with the first header word.
- `Q_EOF`, output, 1: high with the last word of the packet.
- `BUSY`, output, 1: packet in progress (state ≠ IDLE).
- `DONE`, output, 1: one-cycle pulse after the last word transfers.

## Operation
- Transfer rule: a word transfers at a rising edge where `Q_VALID`=1 and `Q_BP`=0.
- While `Q_BP`=1, `Q`, `Q_VALID`, `Q_SOF` and `Q_EOF` hold unchanged. `Q_VALID` never drops mid-packet.
- Header count `H` is `DEST[0][63:56]`, clamped to 1..NumHdr: 0 gives 1, values above NumHdr give NumHdr.
- The header is emitted as `DEST[0]`..`DEST[H-1]`, verbatim from the latched copy.
- Payload: `LEN` words, emitted in full 64-bit width.
  - Default payload is an incrementing counter starting at 0 for each packet.
  - The macro in Configuration changes the payload source.
- State machine:
  - IDLE: on `GO`, latch `DEST`/`LEN`, clear the header index and payload counter, go to HDR.
  - HDR: advance on each transfer. After header word H-1 transfers, go to PAY if `LEN`≠0, else to IDLE.
  - PAY: advance on each transfer. After payload word `LEN`-1 transfers, go to IDLE and pulse `DONE`.
- `GO` is ignored outside IDLE; it is not queued.
- `Q_EOF` marks the last header word when `LEN`=0, otherwise the last payload word. If `H`=1 and `LEN`=0, `Q_SOF` and `Q_EOF` are both high on that single word.
- The payload counter is 64 bits. Wrap-around is not checked; the `LEN` range is the user's concern.

## Timing
- Reset (`RST_N`=0 at an edge): state IDLE, and all outputs 0 on the following cycle (`Q`, `Q_VALID`, `Q_SOF`, `Q_EOF`, `BUSY`, `DONE`).
- Reset mid-packet truncates the packet immediately. There is no EOF and no `DONE`.
- `GO` accepted at edge k: from cycle k+1, `Q_VALID`=1, `Q`=`DEST[0]`, `Q_SOF`=1, `BUSY`=1.
- Without backpressure the packet occupies cycles k+1..k+H+`LEN`, one word per cycle.
- `DONE`=1 and `BUSY`=0 in cycle k+H+`LEN`+1. A `GO` in that cycle is accepted, so back-to-back packets have exactly one idle cycle between them.
- Outputs are fully registered. `Q_BP` reaches state only through the transfer-enable condition; there is no combinational path to outputs.

## Configuration
- Macro `PKT_SRC_LFSR_EN`.
- Defined: payload comes from a 64-bit Fibonacci LFSR, taps 64,63,61,60, seeded with `DEST[0]` XOR 64'h1 at `GO`. The LFSR advances only on a payload transfer.
- Undefined: payload is the incrementing counter; no LFSR logic is present.

## Structure
- `pkt_src_pkg`: state enum (IDLE/HDR/PAY), `HDR_CNT_MSB`=63 / `HDR_CNT_LSB`=56, LFSR tap constant and seed XOR constant.
- One sub-module, `pkt_src_payload`: counter or LFSR, with clear/load and advance-enable inputs and a 64-bit output. The macro selects its body.

## Test plan
- GO with `DEST[0]`={8'h01,56'h4}, `LEN`=500, `Q_BP`=0 -> 501 consecutive words. Word 0 = 64'h0100_0000_0000_0004 with SOF; payload 0..499; EOF on payload 499; `DONE` one cycle later.
- Same packet with `Q_BP` toggled pseudo-randomly -> identical transferred word sequence; outputs stable on every stalled cycle.
- `DEST[0][63:56]`=0 and `LEN`=0 -> single word with SOF=EOF=1. Top byte 8'h0F with NumHdr=8 -> 8 header words only.
- `GO` held high continuously -> packets separated by exactly one idle cycle. `GO` pulses while busy are ignored.
- `RST_N` low during payload word 200 -> outputs 0 next cycle, no `DONE`. The next `GO` restarts cleanly at `DEST[0]`.
- With `PKT_SRC_LFSR_EN` defined -> payload matches the reference LFSR model seeded with `DEST[0]`^1, including under backpressure.
